// File: rtl/hpi_txn_seq.sv
// hpi_txn_seq: HPI read/write strobe sequencer; define HPI_TXN_SEQ_MEMOP_EN for ADDRESS+DATA memory ops
module hpi_txn_seq #(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 3,
    parameter int HOLD_CYC   = 2
) (
    input  logic        Clk,
    input  logic        Reset_N,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_mem,
    input  logic [1:0]  req_addr,
    input  logic [15:0] req_maddr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        busy,
    output logic [1:0]  hpi_address,
    output logic [15:0] hpi_data_out,
    input  logic [15:0] hpi_data_in,
    output logic        hpi_r_n,
    output logic        hpi_w_n,
    output logic        hpi_cs_n
);
    localparam int SC = (SETUP_CYC < 1) ? 1 : SETUP_CYC;
    localparam int TC = (STROBE_CYC < 1) ? 1 : STROBE_CYC;
    localparam int HC = (HOLD_CYC < 2) ? 2 : HOLD_CYC;
    localparam logic [7:0] SC_L = 8'(SC - 1);
    localparam logic [7:0] TC_L = 8'(TC - 1);
    localparam logic [7:0] HC_L = 8'(HC - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD
`ifdef HPI_TXN_SEQ_MEMOP_EN
        , GAP
`endif
    } state_t;

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic        wr_q;
    logic [15:0] cap_q;
    logic        ready_q, busy_q, cs_n_q, r_n_q, w_n_q, rsp_valid_q;
    logic [1:0]  addr_q;
    logic [15:0] dout_q, rdata_q;
`ifdef HPI_TXN_SEQ_MEMOP_EN
    logic        mem_q, wr2_q;
    logic [15:0] wdata2_q;
`else
    logic        unused_mem;
    assign unused_mem = ^{req_mem, req_maddr};
`endif

    always_ff @(posedge Clk) begin
        if (!Reset_N) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            wr_q        <= 1'b0;
            cap_q       <= 16'd0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            cs_n_q      <= 1'b1;
            r_n_q       <= 1'b1;
            w_n_q       <= 1'b1;
            addr_q      <= 2'd0;
            dout_q      <= 16'd0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= 16'd0;
`ifdef HPI_TXN_SEQ_MEMOP_EN
            mem_q       <= 1'b0;
            wr2_q       <= 1'b0;
            wdata2_q    <= 16'd0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
            cnt_q       <= cnt_q + 8'd1;
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (ready_q && req_valid) begin
                        state_q <= SETUP;
                        cnt_q   <= 8'd0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        cs_n_q  <= 1'b0;
                        addr_q  <= req_addr;
                        dout_q  <= req_wdata;
                        wr_q    <= req_write;
`ifdef HPI_TXN_SEQ_MEMOP_EN
                        mem_q    <= req_mem;
                        wr2_q    <= req_write;
                        wdata2_q <= req_wdata;
                        // Memory op starts with a write of the address to the ADDRESS register
                        if (req_mem) begin
                            addr_q <= 2'b10;
                            dout_q <= req_maddr;
                            wr_q   <= 1'b1;
                        end
`endif
                    end
                end
                SETUP: if (cnt_q == SC_L) begin
                    state_q <= STROBE;
                    cnt_q   <= 8'd0;
                    w_n_q   <= !wr_q;
                    r_n_q   <= wr_q;
                end
                STROBE: if (cnt_q == TC_L) begin
                    state_q <= HOLD;
                    cnt_q   <= 8'd0;
                    w_n_q   <= 1'b1;
                    r_n_q   <= 1'b1;
                end
                HOLD: begin
                    // Bus data arrives two cycles late through the registered I/O path
                    if (cnt_q == 8'd1) cap_q <= hpi_data_in;
                    if (cnt_q == HC_L) begin
                        cnt_q  <= 8'd0;
                        cs_n_q <= 1'b1;
`ifdef HPI_TXN_SEQ_MEMOP_EN
                        if (mem_q) begin
                            mem_q   <= 1'b0;
                            state_q <= GAP;
                        end else
`endif
                        begin
                            state_q     <= IDLE;
                            busy_q      <= 1'b0;
                            ready_q     <= 1'b1;
                            rsp_valid_q <= 1'b1;
                            if (!wr_q) rdata_q <= (cnt_q == 8'd1) ? hpi_data_in : cap_q;
                        end
                    end
                end
`ifdef HPI_TXN_SEQ_MEMOP_EN
                GAP: begin
                    state_q <= SETUP;
                    cnt_q   <= 8'd0;
                    cs_n_q  <= 1'b0;
                    addr_q  <= 2'b00;
                    dout_q  <= wdata2_q;
                    wr_q    <= wr2_q;
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready    = ready_q;
    assign busy         = busy_q;
    assign hpi_cs_n     = cs_n_q;
    assign hpi_r_n      = r_n_q;
    assign hpi_w_n      = w_n_q;
    assign hpi_address  = addr_q;
    assign hpi_data_out = dout_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rdata_q;
endmodule

// File: tb/tb_hpi_txn_seq.sv
// tb_hpi_txn_seq: randomized self-checking bench for hpi_txn_seq against a per-cycle phase model
module tb_hpi_txn_seq;
    localparam int S = 1, T = 3, H = 2, L = S + T + H;

    logic        Clk = 1'b0, Reset_N = 1'b0, req_valid = 1'b1, req_write = 1'b0, req_mem = 1'b0;
    logic [1:0]  req_addr = 2'd0;
    logic [15:0] req_maddr = 16'd0, req_wdata = 16'd0, hpi_data_in = 16'd0;
    logic        req_ready, rsp_valid, busy, hpi_r_n, hpi_w_n, hpi_cs_n;
    logic [1:0]  hpi_address;
    logic [15:0] hpi_data_out, rsp_rdata;
    int          n_chk = 0, n_pass = 0;
    logic [15:0] exp_rdata = 16'd0;
    logic        fix_hin = 1'b0;

    always #5 Clk = ~Clk;

    hpi_txn_seq dut (
        .Clk(Clk), .Reset_N(Reset_N), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_mem(req_mem), .req_addr(req_addr), .req_maddr(req_maddr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
        .hpi_address(hpi_address), .hpi_data_out(hpi_data_out), .hpi_data_in(hpi_data_in),
        .hpi_r_n(hpi_r_n), .hpi_w_n(hpi_w_n), .hpi_cs_n(hpi_cs_n)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, want);
    endtask

    // {cs_n, r_n, w_n, busy, req_ready, rsp_valid}
    function automatic logic [5:0] ctl();
        return {hpi_cs_n, hpi_r_n, hpi_w_n, busy, req_ready, rsp_valid};
    endfunction

    task automatic run_txn(input logic w, input logic m, input logic [1:0] a,
                           input logic [15:0] ma, input logic [15:0] wd, input int abort_k);
        int nph, tot, p, o;
        logic [15:0] hist [64];
        logic [1:0] pa;
        logic [15:0] pd;
        logic pw, strobe;
        chk("ready", req_ready, 1);
        req_valid = 1'b1; req_write = w; req_mem = m; req_addr = a; req_maddr = ma; req_wdata = wd;
`ifdef HPI_TXN_SEQ_MEMOP_EN
        nph = m ? 2 : 1;
`else
        nph = 1;
`endif
        tot = nph * (L + 1) - 1;
        for (int k = 0; k <= tot; k++) begin
            @(negedge Clk);
            if (k == tot) begin
                if (!w) exp_rdata = hist[tot - L + S + T + 1];
                chk("done_ctl", ctl(), 6'b111011);
                chk("rdata", rsp_rdata, exp_rdata);
            end else begin
                p = k / (L + 1);
                o = k % (L + 1);
                if (o == L) chk("gap_ctl", ctl(), 6'b111100);
                else begin
                    pa = (nph == 2) ? ((p == 0) ? 2'b10 : 2'b00) : a;
                    pd = (nph == 2 && p == 0) ? ma : wd;
                    pw = (nph == 2 && p == 0) ? 1'b1 : w;
                    strobe = (o >= S) && (o < S + T);
                    chk("ctl", ctl(), {1'b0, !(strobe && !pw), !(strobe && pw), 3'b100});
                    chk("addr", hpi_address, pa);
                    chk("dout", hpi_data_out, pd);
                end
                chk("rdata_hold", rsp_rdata, exp_rdata);
                if (k == abort_k) begin
                    Reset_N = 1'b0;
                    @(negedge Clk);
                    chk("abort_ctl", ctl(), 6'b111000);
                    chk("abort_addr", hpi_address, 0);
                    chk("abort_dout", hpi_data_out, 0);
                    chk("abort_rdata", rsp_rdata, 0);
                    exp_rdata = 16'd0;
                    Reset_N = 1'b1;
                    @(negedge Clk);
                    chk("abort_rel", ctl(), 6'b111010);
                    return;
                end
                hist[k] = fix_hin ? 16'h1234 : 16'($urandom);
                hpi_data_in = hist[k];
                req_valid = 1'($urandom);
                req_write = 1'($urandom);
                req_mem = 1'($urandom);
                req_addr = 2'($urandom);
                req_maddr = 16'($urandom);
                req_wdata = 16'($urandom);
            end
        end
    endtask

    initial begin
        repeat (3) begin
            @(posedge Clk);
            @(negedge Clk);
            chk("rst_ctl", ctl(), 6'b111000);
            chk("rst_addr", hpi_address, 0);
            chk("rst_dout", hpi_data_out, 0);
            chk("rst_rdata", rsp_rdata, 0);
        end
        Reset_N = 1'b1;
        @(negedge Clk);
        chk("rel_ctl", ctl(), 6'b111010);
        run_txn(1'b1, 1'b0, 2'b01, 16'h0000, 16'hBEEF, -1);
        req_valid = 1'b0;
        @(negedge Clk);
        chk("idle_ctl", ctl(), 6'b111010);
        fix_hin = 1'b1;
        run_txn(1'b0, 1'b0, 2'b11, 16'h0000, 16'h5555, -1);
        fix_hin = 1'b0;
        chk("status_rd", rsp_rdata, 16'h1234);
`ifdef HPI_TXN_SEQ_MEMOP_EN
        run_txn(1'b1, 1'b1, 2'b11, 16'h1000, 16'h00AA, -1);
`endif
        run_txn(1'b1, 1'b0, 2'b00, 16'h0000, 16'hA5A5, S + 1);
        for (int i = 0; i < 60; i++) begin
            run_txn(1'($urandom), 1'($urandom), 2'($urandom), 16'($urandom), 16'($urandom), -1);
            if ($urandom_range(0, 1) == 1) begin
                req_valid = 1'b0;
                repeat ($urandom_range(1, 3)) begin
                    @(negedge Clk);
                    chk("idle", ctl(), 6'b111010);
                end
            end
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/hpi_txn_seq.md
HPI_TXN_SEQ -- requirements
Module: hpi_txn_seq

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-low.
REQ-002 Parameter SETUP_CYC, default 1, SHALL set chip-select-to-strobe cycles; values below 1 are treated as 1.
REQ-003 Parameter STROBE_CYC, default 3, SHALL set the strobe-low width in cycles; values below 1 are treated as 1.
REQ-004 Parameter HOLD_CYC, default 2, SHALL set post-strobe cycles with chip-select held; values below 2 are treated as 2.
REQ-005 Ports SHALL be as follows:
- Clk  in  1  clock.
- Reset_N  in  1  synchronous reset, active low.
- req_valid  in  1  request offered.
- req_ready  out  1  request accepted when high together with req_valid.
- req_write  in  1  1 = write, 0 = read.
- req_mem  in  1  1 = memory op: an ADDRESS write, then a DATA access.
- req_addr  in  2  HPI register (00 DATA, 01 MAILBOX, 10 ADDRESS, 11 STATUS); ignored when req_mem=1.
- req_maddr  in  16  memory address, used only when req_mem=1.
- req_wdata  in  16  write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  16  read data, valid with rsp_valid.
- busy  out  1  high in every state except IDLE.
- hpi_address  out  2  to the HPI I/O interface.
- hpi_data_out  out  16  to the HPI I/O interface.
- hpi_data_in  in  16  registered bus data from the HPI I/O interface.
- hpi_r_n, hpi_w_n, hpi_cs_n  out  1 each  active-low strobes.

Function
REQ-006 The FSM states SHALL be IDLE, SETUP, STROBE, HOLD and GAP; all outputs SHALL be registered.
REQ-007 req_ready SHALL be 1 only in IDLE; at handshake the block SHALL latch all req_* fields and enter SETUP on the next cycle.
REQ-008 In SETUP, hpi_cs_n SHALL be 0, hpi_address and hpi_data_out SHALL be driven, and hpi_r_n/hpi_w_n SHALL be 1, for SETUP_CYC cycles.
REQ-009 In STROBE, hpi_w_n (write) or hpi_r_n (read) SHALL be 0 for exactly STROBE_CYC cycles; the two strobes SHALL never be low together.
REQ-010 In HOLD, both strobes SHALL be 1 and hpi_cs_n SHALL be 0 for HOLD_CYC cycles; address and data SHALL stay stable from SETUP through the end of HOLD.
REQ-011 For reads, rsp_rdata SHALL capture hpi_data_in at the end of the second HOLD cycle, which compensates for the 2-cycle registered path of the I/O interface.
REQ-012 After the final HOLD cycle, the block SHALL return to IDLE and pulse rsp_valid for 1 cycle; rsp_rdata SHALL hold its value until the next read completes.
REQ-013 For a memory op, phase 1 SHALL be a write of req_maddr to address 10. Then follow one GAP cycle with hpi_cs_n=1. Phase 2 SHALL be an access to address 00 using req_write/req_wdata. Exactly one rsp_valid SHALL be produced, at the end of phase 2.
REQ-014 hpi_cs_n SHALL be 1 for at least 1 cycle between consecutive transactions, because IDLE always lasts at least 1 cycle.
REQ-015 Cycle counters SHALL be sized for a maximum value of 255; the count resets on each state entry.
REQ-016 req_valid held during a busy transaction SHALL be ignored until the block returns to IDLE.

Reset
REQ-017 While Reset_N=0 at a clock edge, the following SHALL hold: state=IDLE; hpi_cs_n=hpi_r_n=hpi_w_n=1; hpi_address=0; hpi_data_out=0; rsp_valid=0; rsp_rdata=0; busy=0; req_ready=0.
REQ-018 req_ready SHALL rise on the first cycle after Reset_N returns to 1.
REQ-019 A reset mid-transaction SHALL abort the transaction with strobes deasserted on the same edge, and SHALL produce no rsp_valid.

Configuration
REQ-020 With macro HPI_TXN_SEQ_MEMOP_EN defined, req_mem SHALL behave as in REQ-013.
REQ-021 Without HPI_TXN_SEQ_MEMOP_EN, req_mem SHALL be ignored, every request SHALL be a single register access, and the GAP state SHALL not exist.

Verification
REQ-022 Reset: hold Reset_N=0 for 3 cycles with req_valid=1 -> all strobes 1, req_ready=0, no rsp_valid; req_ready=1 one cycle after release.
REQ-023 Write with defaults: addr=01, wdata=0xBEEF -> hpi_cs_n low 6 cycles; hpi_w_n low during cycles 2-4 of those; hpi_r_n stays 1; rsp_valid 1 cycle later.
REQ-024 Read of STATUS: hpi_data_in=0x1234 from the first HOLD cycle onward -> rsp_rdata=0x1234 with the rsp_valid pulse.
REQ-025 Memory write (macro on): maddr=0x1000, wdata=0x00AA -> write 0x1000 to address 10, hpi_cs_n=1 for 1 cycle, write 0x00AA to address 00, one rsp_valid.
REQ-026 Reset asserted during the second STROBE cycle -> strobes 1 the next cycle, no rsp_valid, IDLE after release.
REQ-027 Back-to-back requests with req_valid held high -> 1 cycle of hpi_cs_n=1 between transactions, one rsp_valid per request.
